mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path (requester IF) and the load/store path (requester D).
- Sits between the program counter / instruction fetch logic and the data path on one side, and the memory macro on the other.
- Sequences each access through issue, wait and response phases, and grants the requesters round-robin.
- Its `busy` output drives the processor's stall.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/D arbiter for a single-port memory with fixed read latency
// Optional alignment check enabled by defining MEM_PORT_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner_d;
    logic              r_last_d;
    logic [3:0]        r_cnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_grant;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_win_addr;
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
    logic              r_err;
`endif

    // Grant is combinational in IDLE so the access issues in the same cycle; reset masks it.
    always_comb begin
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_next_state = r_state;
        if (reset && r_state == S_IDLE) begin
            if (if_req && (!d_req || r_last_d)) begin
                w_grant_if = 1'b1;
            end else if (d_req) begin
                w_grant_d = 1'b1;
            end
        end
        w_grant    = w_grant_if || w_grant_d;
        w_win_addr = w_grant_d ? d_addr : if_addr;
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
        w_misalign = w_grant && (w_win_addr[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif
        case (r_state)
            S_IDLE:  if (w_grant) w_next_state = w_misalign ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_last_d    <= 1'b1;
            r_cnt       <= 4'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner_d  <= w_grant_d;
                r_last_d   <= w_grant_d;
                r_cnt      <= LP_CNT_INIT;
                r_mem_addr <= w_win_addr;
                r_mem_we   <= w_grant_d && d_we && !w_misalign;
                if (w_grant_d) r_mem_wdata <= d_wdata;
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
                r_err      <= w_misalign;
`endif
            end else if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) begin
                    // Stores keep the previous load data visible on d_rdata.
                    if (r_owner_d) begin
                        if (!r_mem_we) r_d_rdata <= mem_rdata;
                    end else begin
                        r_if_rdata <= mem_rdata;
                    end
                    r_mem_we <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign if_gnt    = w_grant_if;
    assign d_gnt     = w_grant_d;
    assign mem_en    = w_grant && !w_misalign;
    assign mem_addr  = w_grant ? w_win_addr : r_mem_addr;
    assign mem_we    = w_grant ? (w_grant_d && d_we && !w_misalign) : r_mem_we;
    assign mem_wdata = w_grant_d ? d_wdata : r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_valid  = (r_state == S_RESP) && !r_owner_d;
    assign d_valid   = (r_state == S_RESP) && r_owner_d;
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
    assign d_err     = d_valid && r_err;
`else
    assign d_err     = 1'b0;
`endif
    assign busy      = reset && ((r_state != S_IDLE) || if_req || d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (MEM_LAT = 2)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory image: two fixed words, everything else derived from the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0000_0040: word = 32'h2008_0005;
            32'h0000_0100: word = 32'hCAFE_0100;
            default:       word = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    logic [31:0] r_p1, r_p2;
    always @(posedge clk) begin
        r_p1 <= mem_addr;
        r_p2 <= r_p1;
    end
    assign mem_rdata = word(r_p2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset with a fetch already pending
        tick(); tick(); #1;
        check("rst_if_gnt",    32'(if_gnt), 32'd0);
        check("rst_d_gnt",     32'(d_gnt), 32'd0);
        check("rst_mem_en",    32'(mem_en), 32'd0);
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_d_rdata",   d_rdata, 32'd0);
        check("rst_valids",    32'({if_valid, d_valid, d_err}), 32'd0);

        // Fetch-only at 0x40; T is the release cycle
        tick(); reset = 1'b1; #1;
        check("f_T_if_gnt",   32'(if_gnt), 32'd1);
        check("f_T_d_gnt",    32'(d_gnt), 32'd0);
        check("f_T_mem_en",   32'(mem_en), 32'd1);
        check("f_T_mem_addr", mem_addr, 32'h40);
        check("f_T_mem_we",   32'(mem_we), 32'd0);
        tick(); #1;
        check("f_T1_mem_en",   32'(mem_en), 32'd0);
        check("f_T1_mem_addr", mem_addr, 32'h40);
        check("f_T1_busy",     32'(busy), 32'd1);
        check("f_T1_if_gnt",   32'(if_gnt), 32'd0);
        tick(); #1;
        check("f_T2_if_valid", 32'(if_valid), 32'd0);
        tick(); #1;
        check("f_T3_if_valid", 32'(if_valid), 32'd1);
        check("f_T3_if_rdata", if_rdata, 32'h2008_0005);
        check("f_T3_if_gnt",   32'(if_gnt), 32'd0);
        check("f_T3_d_valid",  32'(d_valid), 32'd0);
        tick(); #1;
        check("f_T4_if_gnt",   32'(if_gnt), 32'd1);
        check("f_T4_if_valid", 32'(if_valid), 32'd0);
        tick(); tick(); tick(); #1;
        check("f_T7_if_valid", 32'(if_valid), 32'd1);
        if_req = 1'b0;
        tick(); #1;
        check("f_T8_if_gnt", 32'(if_gnt), 32'd0);
        check("f_T8_busy",   32'(busy), 32'd0);

        // Store 0xDEADBEEF to 0x80; write data must stay captured after d_wdata changes
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF; #1;
        check("s_T_d_gnt",     32'(d_gnt), 32'd1);
        check("s_T_mem_en",    32'(mem_en), 32'd1);
        check("s_T_mem_we",    32'(mem_we), 32'd1);
        check("s_T_mem_addr",  mem_addr, 32'h80);
        check("s_T_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        for (int k = 1; k <= 2; k++) begin
            tick(); d_wdata = 32'h0; d_addr = 32'h4; #1;
            check("s_hold_mem_we",    32'(mem_we), 32'd1);
            check("s_hold_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("s_hold_mem_addr",  mem_addr, 32'h80);
            check("s_hold_mem_en",    32'(mem_en), 32'd0);
        end
        tick(); #1;
        check("s_T3_d_valid", 32'(d_valid), 32'd1);
        check("s_T3_d_rdata", d_rdata, 32'd0);
        check("s_T3_d_err",   32'(d_err), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); #1;
        check("s_T4_d_valid", 32'(d_valid), 32'd0);

        // Load of 0x100 interrupted by reset at T+1
        d_req = 1'b1; d_addr = 32'h100; #1;
        check("r_T_d_gnt", 32'(d_gnt), 32'd1);
        tick(); reset = 1'b0; #1;
        check("r_rst_d_valid",  32'(d_valid), 32'd0);
        check("r_rst_mem_addr", mem_addr, 32'd0);
        check("r_rst_mem_we",   32'(mem_we), 32'd0);
        check("r_rst_if_rdata", if_rdata, 32'd0);
        check("r_rst_d_gnt",    32'(d_gnt), 32'd0);
        tick(); tick(); #1;
        check("r_rst_d_valid2", 32'(d_valid), 32'd0);

        // Release with both requesting: IF, D, IF, D at 4-cycle spacing
        tick(); reset = 1'b1; if_req = 1'b1; #1;
        check("c0_if_gnt", 32'(if_gnt), 32'd1);
        check("c0_d_gnt",  32'(d_gnt), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            tick(); #1;
            if (if_valid && d_valid) check("c_both_valid", 32'd1, 32'd0);
            if (k == 3) check("c3_if_valid", 32'(if_valid), 32'd1);
            if (k == 3) check("c3_d_valid", 32'(d_valid), 32'd0);
            if (k == 4) check("c4_d_gnt", 32'(d_gnt), 32'd1);
            if (k == 4) check("c4_if_gnt", 32'(if_gnt), 32'd0);
            if (k == 4) check("c4_mem_addr", mem_addr, 32'h100);
            if (k == 5) check("c5_gnts", 32'({if_gnt, d_gnt}), 32'd0);
            if (k == 7) check("c7_d_valid", 32'(d_valid), 32'd1);
            if (k == 7) check("c7_d_rdata", d_rdata, 32'hCAFE_0100);
            if (k == 8) check("c8_if_gnt", 32'(if_gnt), 32'd1);
            if (k == 12) check("c12_d_gnt", 32'(d_gnt), 32'd1);
            if (k == 12) if_req = 1'b0;
            if (k == 15) check("c15_d_valid", 32'(d_valid), 32'd1);
            if (k == 15) d_req = 1'b0;
        end
        tick(); #1;
        check("c16_busy", 32'(busy), 32'd0);

        // Misaligned load at 0x102
        tick(); d_req = 1'b1; d_addr = 32'h102; d_we = 1'b0; #1;
        check("a_T_d_gnt", 32'(d_gnt), 32'd1);
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
        check("a_T_mem_en", 32'(mem_en), 32'd0);
        tick(); #1;
        check("a_T1_d_valid", 32'(d_valid), 32'd1);
        check("a_T1_d_err",   32'(d_err), 32'd1);
        check("a_T1_d_rdata", d_rdata, 32'hCAFE_0100);
        check("a_T1_mem_en",  32'(mem_en), 32'd0);
`else
        check("a_T_mem_en",   32'(mem_en), 32'd1);
        check("a_T_mem_addr", mem_addr, 32'h102);
        tick(); tick(); tick(); #1;
        check("a_T3_d_valid", 32'(d_valid), 32'd1);
        check("a_T3_d_err",   32'(d_err), 32'd0);
        check("a_T3_d_rdata", d_rdata, 32'hA5A5_0102);
`endif
        d_req = 1'b0;
        tick(); #1;
        check("a_end_d_valid", 32'(d_valid), 32'd0);
        check("a_end_d_err",   32'(d_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
